td4_exec_ctrl: RTL and testbench

//  Drive side of the register_4bit LOAD/IN_DATA interface: decodes the TD4 instruction
//  (OP/IM), selects an operand (A, B, input port or zero), adds IM, and generates LOAD and
//  IN_DATA for the register file. It holds the carry flag and a small INIT/RUN/HALT

---
 rtl/td4_exec_ctrl.sv | 93 +++++++++
 tb/tb_td4_exec_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/td4_exec_ctrl.sv
// TD4 execute control: decodes OP/IM, picks an operand, adds IM, drives register_4bit LOAD/IN_DATA.
// Zero latency for LOAD/IN_DATA (combinational); CARRY and the INIT/RUN/HALT state are registered.
module td4_exec_ctrl (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] OP,
    input  logic [3:0] IM,
    input  logic [3:0] REG_A,
    input  logic [3:0] REG_B,
    input  logic [3:0] IN_PORT,
    input  logic [3:0] ADDRESS,
    input  logic       RESUME,
    output logic [3:0] LOAD,
    output logic [3:0] IN_DATA,
    output logic       CARRY,
    output logic       HALTED
);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] sel;
    logic [3:0] run_load;
    logic [4:0] sum;
    logic       self_jump;

    // LOAD bit order is {PC,OUT,B,A}, active low.
    always_comb begin
        sel      = 4'h0;
        run_load = 4'b1111;
        case (OP)
            4'b0000: begin sel = REG_A;   run_load = 4'b1110; end
            4'b0001: begin sel = REG_B;   run_load = 4'b1110; end
            4'b0010: begin sel = IN_PORT; run_load = 4'b1110; end
            4'b0011: begin sel = 4'h0;    run_load = 4'b1110; end
            4'b0100: begin sel = REG_A;   run_load = 4'b1101; end
            4'b0101: begin sel = REG_B;   run_load = 4'b1101; end
            4'b0110: begin sel = IN_PORT; run_load = 4'b1101; end
            4'b0111: begin sel = 4'h0;    run_load = 4'b1101; end
            4'b1001: begin sel = REG_B;   run_load = 4'b1011; end
            4'b1011: begin sel = 4'h0;    run_load = 4'b1011; end
            4'b1110: begin sel = 4'h0;    run_load = CARRY ? 4'b1111 : 4'b0111; end
            4'b1111: begin sel = 4'h0;    run_load = 4'b0111; end
            default: begin sel = 4'h0;    run_load = 4'b1111; end
        endcase
    end

    assign sum       = {1'b0, sel} + {1'b0, IM};
    assign self_jump = ~run_load[3] && (IM == ADDRESS);
    assign HALTED    = (state == ST_HALT);

    always_comb begin
        LOAD    = 4'b0111;
        IN_DATA = 4'h0;
        case (state)
            ST_RUN: begin
                LOAD    = run_load;
                IN_DATA = sum[3:0];
            end
            ST_HALT: begin
                // Releasing the PC on resume lets it count past the self-loop.
                LOAD    = RESUME ? 4'b1111 : 4'b0111;
                IN_DATA = ADDRESS;
            end
            default: begin
                LOAD    = 4'b0111;
                IN_DATA = 4'h0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= ST_INIT;
            CARRY <= 1'b0;
        end else begin
            case (state)
                ST_INIT: state <= ST_RUN;
                ST_RUN: begin
                    CARRY <= sum[4];
                    if (self_jump) state <= ST_HALT;
                end
                ST_HALT: if (RESUME) state <= ST_RUN;
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_td4_exec_ctrl.sv
// Directed-vector bench for td4_exec_ctrl; inputs change on the falling edge,
// combinational outputs are checked just after it, registered ones just after the rising edge.
module tb_td4_exec_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] op, im, reg_a, reg_b, in_port, address;
    logic       resume;
    logic [3:0] load, in_data;
    logic       carry, halted;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    td4_exec_ctrl dut (
        .CLK     (clk),
        .RST     (rst),
        .OP      (op),
        .IM      (im),
        .REG_A   (reg_a),
        .REG_B   (reg_b),
        .IN_PORT (in_port),
        .ADDRESS (address),
        .RESUME  (resume),
        .LOAD    (load),
        .IN_DATA (in_data),
        .CARRY   (carry),
        .HALTED  (halted)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic drive(input logic [3:0] o, input logic [3:0] i);
        @(negedge clk);
        op = o;
        im = i;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("%0d/%0d checks passed", n_pass, n_chk + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; op = 4'h8; im = 4'h0; reg_a = 4'h0; reg_b = 4'h0;
        in_port = 4'h0; address = 4'h0; resume = 1'b0;
        #3 rst = 1'b0;
        #1;
        check("rst_load", 8'(load), 8'h07);
        check("rst_data", 8'(in_data), 8'h00);
        check("rst_carry", 8'(carry), 8'h0);
        check("rst_halted", 8'(halted), 8'h0);
        tick();

        // Release reset: one INIT cycle, then RUN
        @(negedge clk); rst = 1'b1; op = 4'h0; reg_a = 4'hC; im = 4'h5; #1;
        check("init_load", 8'(load), 8'h07);
        tick();
        #1;
        check("add_a_load", 8'(load), 8'h0E);
        check("add_a_data", 8'(in_data), 8'h01);
        tick();
        check("add_a_carry", 8'(carry), 8'h1);

        // JNC not taken with CARRY=1; 0+9 clears carry
        address = 4'h2;
        drive(4'hE, 4'h9);
        check("jnc_c1_load", 8'(load), 8'h0F);
        tick();
        check("jnc_carry_clr", 8'(carry), 8'h0);
        drive(4'hE, 4'h9);
        check("jnc_c0_load", 8'(load), 8'h07);
        check("jnc_c0_data", 8'(in_data), 8'h09);
        tick();
        check("jnc_no_halt", 8'(halted), 8'h0);

        drive(4'h3, 4'h3);
        check("mov_a_load", 8'(load), 8'h0E);
        check("mov_a_data", 8'(in_data), 8'h03);
        tick();
        check("mov_a_carry", 8'(carry), 8'h0);

        // Operand routing
        in_port = 4'hA;
        drive(4'h6, 4'h0);
        check("in_b_load", 8'(load), 8'h0D);
        check("in_b_data", 8'(in_data), 8'h0A);
        reg_b = 4'h6;
        drive(4'h9, 4'h0);
        check("out_b_load", 8'(load), 8'h0B);
        check("out_b_data", 8'(in_data), 8'h06);
        reg_a = 4'h4;
        drive(4'h4, 4'h2);
        check("mov_b_a_data", 8'(in_data), 8'h06);
        check("mov_b_a_load", 8'(load), 8'h0D);

        // ADD B overflow, then a NOP still rewrites CARRY; RESUME ignored in RUN
        reg_b = 4'hF;
        drive(4'h5, 4'h1);
        check("add_b_load", 8'(load), 8'h0D);
        check("add_b_data", 8'(in_data), 8'h00);
        tick();
        check("add_b_carry", 8'(carry), 8'h1);
        @(negedge clk); op = 4'h8; im = 4'h4; resume = 1'b1; #1;
        check("nop_load", 8'(load), 8'h0F);
        check("nop_data", 8'(in_data), 8'h04);
        tick();
        check("nop_carry", 8'(carry), 8'h0);
        check("resume_run", 8'(halted), 8'h0);
        @(negedge clk); resume = 1'b0;
        drive(4'hB, 4'hD);
        check("out_im_load", 8'(load), 8'h0B);

        // JMP to self -> HALT
        address = 4'h7;
        drive(4'hF, 4'h7);
        check("jmp_self_load", 8'(load), 8'h07);
        check("jmp_self_data", 8'(in_data), 8'h07);
        tick();
        check("halted_set", 8'(halted), 8'h1);
        @(negedge clk); op = 4'h0; reg_a = 4'hF; im = 4'hF;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("halt_load", 8'(load), 8'h07);
            check("halt_data", 8'(in_data), 8'h07);
            tick();
            check("halt_carry", 8'(carry), 8'h0);
            check("halt_hold", 8'(halted), 8'h1);
            @(negedge clk);
        end
        resume = 1'b1; #1;
        check("resume_load", 8'(load), 8'h0F);
        tick();
        check("resume_halted", 8'(halted), 8'h0);
        @(negedge clk); resume = 1'b0; #1;
        check("after_resume_load", 8'(load), 8'h0E);
        tick();
        check("after_resume_carry", 8'(carry), 8'h1);

        // Carry set to 1 then JNC not taken even to self address
        address = 4'h3;
        drive(4'hE, 4'h3);
        check("jnc_self_c1", 8'(load), 8'h0F);
        tick();
        check("jnc_self_nohalt", 8'(halted), 8'h0);
        drive(4'hE, 4'h3);
        check("jnc_self_load", 8'(load), 8'h07);
        tick();
        check("jnc_halt", 8'(halted), 8'h1);
        #2;
        check("halt_pc_data", 8'(in_data), 8'h03);

        // Asynchronous reset inside HALT
        rst = 1'b0;
        #1;
        check("rst_halt_halted", 8'(halted), 8'h0);
        check("rst_halt_load", 8'(load), 8'h07);
        check("rst_halt_data", 8'(in_data), 8'h00);
        @(negedge clk); rst = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
